// File: rtl/if_fetch_pkg.sv
// Shared constants for the fetch stage: hand-off status codes, fetch FSM encodings and reset PC.
package if_fetch_pkg;

  localparam logic [1:0]  MMIF_OK_NONE     = 2'b00;
  localparam logic [1:0]  MMIF_OK_VALID    = 2'b01;

  localparam logic [0:0]  ST_FETCH         = 1'b0;
  localparam logic [0:0]  ST_READY         = 1'b1;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: assembles each 32-bit word from four little-endian byte reads and holds it
// for the IF/ID register until accepted or redirected.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          MEM_AW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stl_mm,
  input  logic              br_flag,
  input  logic [31:0]       br_target,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic              mem_grant,
  input  logic [7:0]        mem_din,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_is,
  output logic [1:0]        mmif_ok
);

  logic [0:0]  r_state;
  logic [31:0] r_pc;
  logic [2:0]  r_req_cnt;
  logic [2:0]  r_rcv_cnt;
  logic        r_pend;
  logic        r_discard;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_is;
  logic [1:0]  r_mmif_ok;

  logic        w_fetch;
  logic        w_req;
  logic        w_grant;
  logic        w_rcv;
  logic        w_last;
  logic [31:0] w_addr;

  always_comb begin
    w_fetch = (r_state == ST_FETCH);
    w_req   = w_fetch && !r_req_cnt[2] && !rst;
    w_grant = w_req && mem_grant;
    // A byte arrives one cycle after its grant; a grant made in a redirect cycle is dropped.
    w_rcv   = w_fetch && r_pend && !r_discard;
    w_last  = w_rcv && (r_rcv_cnt == 3'd3);
    w_addr  = r_pc + {29'd0, r_req_cnt};
  end

  assign mem_req  = w_req;
  assign mem_addr = w_addr[MEM_AW-1:0];
  assign if_pc    = r_if_pc;
  assign if_is    = r_if_is;
  assign mmif_ok  = r_mmif_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_pc      <= RESET_PC;
      r_req_cnt <= 3'd0;
      r_rcv_cnt <= 3'd0;
      r_pend    <= 1'b0;
      r_discard <= 1'b0;
      r_if_pc   <= RESET_PC;
      r_if_is   <= 32'd0;
      r_mmif_ok <= MMIF_OK_NONE;
    end else begin
      r_pend    <= w_grant;
      r_discard <= br_flag && w_grant;
      if (br_flag) begin
        r_pc      <= br_target;
        r_mmif_ok <= MMIF_OK_NONE;
        r_req_cnt <= 3'd0;
        r_rcv_cnt <= 3'd0;
        r_state   <= ST_FETCH;
      end else if (r_state == ST_READY) begin
        if (!stl_mm) begin
          r_pc      <= r_pc + 32'd4;
          r_mmif_ok <= MMIF_OK_NONE;
          r_req_cnt <= 3'd0;
          r_rcv_cnt <= 3'd0;
          r_state   <= ST_FETCH;
        end
      end else begin
        if (w_grant) begin
          r_req_cnt <= r_req_cnt + 3'd1;
        end
        if (w_rcv) begin
          r_if_is[{r_rcv_cnt[1:0], 3'b000} +: 8] <= mem_din;
          r_rcv_cnt <= r_rcv_cnt + 3'd1;
        end
        if (w_last) begin
          r_if_pc   <= r_pc;
          r_mmif_ok <= MMIF_OK_VALID;
          r_state   <= ST_READY;
        end
      end
    end
  end

endmodule
